// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if
// Command/status bundle between a host controller and the PS/2 host transmitter.
//   cmd_data  [7:0] byte to send, sampled when cmd_valid & cmd_ready
//   cmd_valid       command request from the controller
//   cmd_ready       transmitter idle and able to accept a byte
//   tx_busy         frame in progress (the receive path ignores the bus while high)
//   tx_done         1-cycle pulse: frame sent and the device acknowledged
//   tx_error        1-cycle pulse: frame failed, reason in err_code
//   err_code  [1:0] 01 no-ack, 10 request timeout, 11 packet timeout
// Modports: master = command source, slave = transmitter.
interface ps2_host_tx_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic [1:0] err_code;

  modport master (
    output cmd_data, cmd_valid,
    input  cmd_ready, tx_busy, tx_done, tx_error, err_code
  );

  modport slave (
    input  cmd_data, cmd_valid,
    output cmd_ready, tx_busy, tx_done, tx_error, err_code
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter. Inhibits the bus, issues a request-to-send,
// shifts out data/parity/stop on the device-generated clock and checks the ack.
//   CLOCK_50    system clock
//   resetn      asynchronous active-low reset; releases both lines at once
//   cmd         command/status bundle (slave side)
//   ps2_clk_in  PS2_CLK pad value (asynchronous)
//   ps2_dat_in  PS2_DAT pad value (asynchronous)
//   ps2_clk_oe  1 = pull PS2_CLK low (registered)
//   ps2_dat_oe  1 = pull PS2_DAT low (registered)
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int REQ_TIMEOUT    = 750000,
  parameter int PKT_TIMEOUT    = 100000
) (
  input  logic         CLOCK_50,
  input  logic         resetn,
  ps2_host_tx_if.slave cmd,
  input  logic         ps2_clk_in,
  input  logic         ps2_dat_in,
  output logic         ps2_clk_oe,
  output logic         ps2_dat_oe
);
  localparam int MAX_A = (INHIBIT_CYCLES > REQ_TIMEOUT) ? INHIBIT_CYCLES : REQ_TIMEOUT;
  localparam int MAX_P = (MAX_A > PKT_TIMEOUT) ? MAX_A : PKT_TIMEOUT;
  localparam int CW    = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] REQ_LAST = CW'(REQ_TIMEOUT - 1);
  localparam logic [CW-1:0] PKT_LAST = CW'(PKT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, START, REQ, BITS, ACK, WAIT_IDLE, ERR
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [3:0]    bit_cnt_reg, bit_cnt_next;
  logic [9:0]    shift_reg, shift_next;
  logic          ack_err_reg, ack_err_next;
  logic [1:0]    err_code_reg, err_code_next;
  logic          clk_oe_reg, clk_oe_next;
  logic          dat_oe_reg, dat_oe_next;
  logic          done_reg, done_next;
  logic          error_reg, error_next;
  logic          clk_sync1_reg, clk_sync2_reg, clk_prev_reg;
  logic          dat_sync1_reg, dat_sync2_reg;
  logic          fall;

  // Device clock falling edge, seen after the synchronizer plus one history flop.
  assign fall    = clk_prev_reg & ~clk_sync2_reg;
  // Saturating increment: a stuck counter must never wrap back into range.
  assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CW'(1);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      ack_err_reg   <= 1'b0;
      err_code_reg  <= 2'b00;
      clk_oe_reg    <= 1'b0;
      dat_oe_reg    <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
      clk_sync1_reg <= 1'b1;
      clk_sync2_reg <= 1'b1;
      clk_prev_reg  <= 1'b1;
      dat_sync1_reg <= 1'b1;
      dat_sync2_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      ack_err_reg   <= ack_err_next;
      err_code_reg  <= err_code_next;
      clk_oe_reg    <= clk_oe_next;
      dat_oe_reg    <= dat_oe_next;
      done_reg      <= done_next;
      error_reg     <= error_next;
      clk_sync1_reg <= ps2_clk_in;
      clk_sync2_reg <= clk_sync1_reg;
      clk_prev_reg  <= clk_sync2_reg;
      dat_sync1_reg <= ps2_dat_in;
      dat_sync2_reg <= dat_sync1_reg;
    end
  end

  // Line drivers are computed for the *next* state and registered, so the
  // pad enables change cleanly on the same edge as the state.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    ack_err_next  = ack_err_reg;
    err_code_next = err_code_reg;
    dat_oe_next   = dat_oe_reg;
    done_next     = 1'b0;
    error_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        dat_oe_next = 1'b0;
        if (cmd.cmd_valid) begin
          shift_next    = {1'b1, ~^cmd.cmd_data, cmd.cmd_data};
          err_code_next = 2'b00;
          ack_err_next  = 1'b0;
          cnt_next      = '0;
          state_next    = INHIBIT;
        end
      end
      INHIBIT: begin
        dat_oe_next = 1'b0;
        if (cnt_reg >= INH_LAST) begin
          cnt_next    = '0;
          dat_oe_next = 1'b1;   // start bit goes on the line together with the clock hold
          state_next  = START;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      START: begin
        dat_oe_next  = 1'b1;
        cnt_next     = '0;
        bit_cnt_next = '0;
        state_next   = REQ;
      end
      REQ: begin
        if (fall) begin
          dat_oe_next  = ~shift_reg[0];
          shift_next   = {1'b0, shift_reg[9:1]};
          bit_cnt_next = 4'd1;
          cnt_next     = '0;    // packet timer starts at the first device edge
          state_next   = BITS;
        end else if (cnt_reg >= REQ_LAST) begin
          err_code_next = 2'b10;
          dat_oe_next   = 1'b0;
          state_next    = ERR;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      BITS: begin
        if (cnt_reg >= PKT_LAST) begin
          err_code_next = 2'b11;
          dat_oe_next   = 1'b0;
          state_next    = ERR;
        end else begin
          cnt_next = cnt_inc;
          if (fall) begin
            dat_oe_next  = ~shift_reg[0];
            shift_next   = {1'b0, shift_reg[9:1]};
            bit_cnt_next = bit_cnt_reg + 4'd1;
            // Edge #10 puts the stop bit (released line) out; the next edge is the ack.
            if (bit_cnt_reg == 4'd9) state_next = ACK;
          end
        end
      end
      ACK: begin
        dat_oe_next = 1'b0;
        if (cnt_reg >= PKT_LAST) begin
          err_code_next = 2'b11;
          state_next    = ERR;
        end else begin
          cnt_next = cnt_inc;
          if (fall) begin
            ack_err_next = dat_sync2_reg;
            cnt_next     = '0;
            state_next   = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        dat_oe_next = 1'b0;
        if (cnt_reg >= PKT_LAST) begin
          err_code_next = 2'b11;  // timeout wins over an already-decided result
          state_next    = ERR;
        end else if (clk_sync2_reg && dat_sync2_reg) begin
          state_next = IDLE;
          if (ack_err_reg) begin
            err_code_next = 2'b01;
            error_next    = 1'b1;
          end else begin
            done_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_inc;
        end
      end
      ERR: begin
        dat_oe_next = 1'b0;
        state_next  = IDLE;
      end
      default: begin
        dat_oe_next = 1'b0;
        state_next  = IDLE;
      end
    endcase

    if (state_next == ERR) error_next = 1'b1;
    clk_oe_next = (state_next == INHIBIT) || (state_next == START);
  end

  assign ps2_clk_oe    = clk_oe_reg;
  assign ps2_dat_oe    = dat_oe_reg;
  assign cmd.cmd_ready = (state_reg == IDLE);
  assign cmd.tx_busy   = (state_reg != IDLE);
  assign cmd.tx_done   = done_reg;
  assign cmd.tx_error  = error_reg;
  assign cmd.err_code  = err_code_reg;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
// Directed bench for ps2_host_tx: a behavioural keyboard drives the open-drain
// bus and captures the bits it sees on each rising clock edge.
module tb_ps2_host_tx;
  localparam int INH  = 50;
  localparam int REQT = 400;
  localparam int PKT  = 2000;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b1;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic ps2_clk_oe, ps2_dat_oe;
  logic clk_pad, dat_pad;

  assign clk_pad = ~(ps2_clk_oe | dev_clk_low);
  assign dat_pad = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx_if cmd_if();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_TIMEOUT   (REQT),
    .PKT_TIMEOUT   (PKT)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .cmd       (cmd_if.slave),
    .ps2_clk_in(clk_pad),
    .ps2_dat_in(dat_pad),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit track    = 1'b0;
  bit busy_gap = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic tick();
    @(negedge CLOCK_50);
    if (track && (!cmd_if.tx_busy || cmd_if.cmd_ready)) busy_gap = 1'b1;
  endtask

  task automatic accept(input logic [7:0] b);
    @(negedge CLOCK_50);
    check("ready_before_accept", 32'(cmd_if.cmd_ready), 32'd1);
    cmd_if.cmd_data  = b;
    cmd_if.cmd_valid = 1'b1;
    @(negedge CLOCK_50);
    cmd_if.cmd_valid = 1'b0;
    check("busy_after_accept", 32'(cmd_if.tx_busy), 32'd1);
  endtask

  // Ends on the START cycle.
  task automatic inhibit_phase();
    int n;
    n = 0;
    while (ps2_clk_oe && !ps2_dat_oe && n < INH + 100) begin
      n++;
      tick();
    end
    check("inhibit_len", 32'(n), 32'(INH));
    check("start_clk_oe", 32'(ps2_clk_oe), 32'd1);
    check("start_dat_oe", 32'(ps2_dat_oe), 32'd1);
  endtask

  task automatic req_phase();
    tick();
    check("req_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("req_dat_oe", 32'(ps2_dat_oe), 32'd1);
  endtask

  // Keyboard: start bit read before the first fall, then one bit per rising edge.
  task automatic dev_edges(input int n, input bit ack, output logic [10:0] bits, output int fall1);
    bits    = '0;
    fall1   = 0;
    bits[0] = dat_pad;
    for (int k = 1; k <= n; k++) begin
      repeat (10) tick();
      dev_clk_low = 1'b1;
      if (k == 1) fall1 = cyc;
      repeat (10) tick();
      dev_clk_low = 1'b0;
      if (k <= 10) bits[k] = dat_pad;
      if (k == 10 && ack) dev_dat_low = 1'b1;
      if (k == 11) dev_dat_low = 1'b0;
    end
  endtask

  task automatic wait_result(output int d, output int e);
    d = 0;
    e = 0;
    for (int i = 0; i < PKT + 200 && (d + e) == 0; i++) begin
      @(negedge CLOCK_50);
      if (cmd_if.tx_done)  d++;
      if (cmd_if.tx_error) e++;
      if (track && (d + e) == 0 && !cmd_if.tx_busy) busy_gap = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK_50);
      if (cmd_if.tx_done)  d++;
      if (cmd_if.tx_error) e++;
    end
  endtask

  initial begin
    logic [10:0] bits;
    int fall1, d, e, n, act;

    cmd_if.cmd_data  = 8'h00;
    cmd_if.cmd_valid = 1'b0;
    #5 resetn = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    #1;
    check("rst_ready",    32'(cmd_if.cmd_ready), 32'd1);
    check("rst_busy",     32'(cmd_if.tx_busy),   32'd0);
    check("rst_clk_oe",   32'(ps2_clk_oe),       32'd0);
    check("rst_dat_oe",   32'(ps2_dat_oe),       32'd0);
    check("rst_done",     32'(cmd_if.tx_done),   32'd0);
    check("rst_error",    32'(cmd_if.tx_error),  32'd0);
    check("rst_err_code", 32'(cmd_if.err_code),  32'd0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    repeat (5) @(negedge CLOCK_50);

    // 1) 0xF4 with ack
    accept(8'hF4);
    inhibit_phase();
    req_phase();
    dev_edges(11, 1'b1, bits, fall1);
    wait_result(d, e);
    check("t1_bits",  32'(bits), 32'(frame_of(8'hF4)));
    check("t1_done",  32'(d), 32'd1);
    check("t1_error", 32'(e), 32'd0);
    $display("T1 send F4: bits=%b done=%0d error=%0d", bits, d, e);

    // 2) 0xED with ack; a second request during the frame must be dropped
    track    = 1'b1;
    busy_gap = 1'b0;
    accept(8'hED);
    inhibit_phase();
    req_phase();
    cmd_if.cmd_data  = 8'h00;
    cmd_if.cmd_valid = 1'b1;
    tick();
    cmd_if.cmd_valid = 1'b0;
    dev_edges(11, 1'b1, bits, fall1);
    wait_result(d, e);
    track = 1'b0;
    check("t2_bits",     32'(bits), 32'(frame_of(8'hED)));
    check("t2_parity",   32'(bits[9]), 32'd1);
    check("t2_done",     32'(d), 32'd1);
    check("t2_error",    32'(e), 32'd0);
    check("t2_busy_gap", 32'(busy_gap), 32'd0);
    act = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLOCK_50);
      if (ps2_clk_oe || cmd_if.tx_busy) act++;
    end
    check("t2_dropped_cmd", 32'(act), 32'd0);
    $display("T2 send ED: bits=%b done=%0d error=%0d extra_activity=%0d", bits, d, e, act);

    // 3) no ack from device
    accept(8'hFF);
    inhibit_phase();
    req_phase();
    dev_edges(11, 1'b0, bits, fall1);
    wait_result(d, e);
    check("t3_done",     32'(d), 32'd0);
    check("t3_error",    32'(e), 32'd1);
    check("t3_err_code", 32'(cmd_if.err_code), 32'd1);
    check("t3_clk_oe",   32'(ps2_clk_oe), 32'd0);
    check("t3_dat_oe",   32'(ps2_dat_oe), 32'd0);
    check("t3_idle",     32'(cmd_if.cmd_ready), 32'd1);
    $display("T3 send FF no-ack: done=%0d error=%0d err_code=%0d", d, e, cmd_if.err_code);

    // 4) device never clocks
    accept(8'h55);
    check("t4_err_code_cleared", 32'(cmd_if.err_code), 32'd0);
    inhibit_phase();
    n = 0;
    while (!cmd_if.tx_error && n < REQT + 50) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("t4_req_timeout_cycles", 32'(n), 32'(REQT + 1));
    check("t4_err_code", 32'(cmd_if.err_code), 32'd2);
    check("t4_clk_oe",   32'(ps2_clk_oe), 32'd0);
    check("t4_dat_oe",   32'(ps2_dat_oe), 32'd0);
    @(negedge CLOCK_50);
    check("t4_idle", 32'(cmd_if.cmd_ready), 32'd1);
    $display("T4 send 55 req-timeout: cycles=%0d err_code=%0d", n, cmd_if.err_code);

    // 5) device stops after 5 edges
    accept(8'hAA);
    inhibit_phase();
    req_phase();
    dev_edges(5, 1'b0, bits, fall1);
    n = 0;
    while (!cmd_if.tx_error && n < PKT + 100) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("t5_pkt_timeout_cycles", 32'(cyc - fall1), 32'(PKT + 3));
    check("t5_err_code", 32'(cmd_if.err_code), 32'd3);
    check("t5_dat_oe",   32'(ps2_dat_oe), 32'd0);
    repeat (3) @(negedge CLOCK_50);
    $display("T5 send AA pkt-timeout: cycles_from_edge1=%0d err_code=%0d", cyc - fall1, cmd_if.err_code);

    // 6) reset in the middle of the data bits, then a clean frame
    accept(8'h3C);
    inhibit_phase();
    req_phase();
    dev_edges(4, 1'b0, bits, fall1);
    resetn = 1'b0;
    #1;
    check("t6_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("t6_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("t6_ready",  32'(cmd_if.cmd_ready), 32'd1);
    d = 0;
    e = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK_50);
      if (cmd_if.tx_done)  d++;
      if (cmd_if.tx_error) e++;
    end
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK_50);
      if (cmd_if.tx_done)  d++;
      if (cmd_if.tx_error) e++;
    end
    check("t6_no_pulses", 32'(d + e), 32'd0);
    $display("T6 reset mid-frame: clk_oe=%0d dat_oe=%0d pulses=%0d", ps2_clk_oe, ps2_dat_oe, d + e);

    accept(8'h12);
    inhibit_phase();
    req_phase();
    dev_edges(11, 1'b1, bits, fall1);
    wait_result(d, e);
    check("t6b_bits",  32'(bits), 32'(frame_of(8'h12)));
    check("t6b_done",  32'(d), 32'd1);
    check("t6b_error", 32'(e), 32'd0);
    $display("T6b send 12 after reset: bits=%b done=%0d error=%0d", bits, d, e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
